simd_alu_issue_ctrl: RTL
========================

// Module: simd_alu_issue_ctrl
// PURPOSE
//  Initiator side of the SIMD ALU operand/result interface. Accepts one
//  command (a, b, opcode, tag) on a valid/ready port and drives the ALU
//  operand/opcode inputs, holding them stable for the ALU's fixed latency.
//  Captures result and per-byte-lane overflow/underflow, then returns them
//  with the tag on a valid/ready response port. One transaction in flight.
// PARAMETERS
//  SIMD_DATA_WIDTH  256  operand/result width; multiple of 64
//  SIMD_OPC_WIDTH   from simd_alu_defines.vh; opcode width
//  TAG_WIDTH        4    caller transaction tag width
//  ALU_LATENCY      1    cycles from ALU operand sample edge to valid out; >=1
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   sync active-low reset
//  cmd_valid    in   1                   command valid
//  cmd_ready    out  1                   command accepted when valid&ready
//  cmd_a        in   SIMD_DATA_WIDTH     operand A
//  cmd_b        in   SIMD_DATA_WIDTH     operand B
//  cmd_opcode   in   SIMD_OPC_WIDTH      ALU opcode
//  cmd_tag      in   TAG_WIDTH           tag echoed on response
//  alu_a        out  SIMD_DATA_WIDTH     to ALU in_a
//  alu_b        out  SIMD_DATA_WIDTH     to ALU in_b
//  alu_opcode   out  SIMD_OPC_WIDTH      to ALU opcode
//  alu_out      in   SIMD_DATA_WIDTH     from ALU out
//  alu_ovf      in   SIMD_DATA_WIDTH/8   from ALU out_overflow
//  alu_udf      in   SIMD_DATA_WIDTH/8   from ALU out_underflow
//  rsp_valid    out  1                   response valid
//  rsp_ready    in   1                   response consumed when valid&ready
//  rsp_data     out  SIMD_DATA_WIDTH     captured result
//  rsp_ovf      out  SIMD_DATA_WIDTH/8   captured overflow flags
//  rsp_udf      out  SIMD_DATA_WIDTH/8   captured underflow flags
//  rsp_tag      out  TAG_WIDTH           tag of the transaction
//  rsp_err      out  1                   1 = illegal opcode, no ALU op done
//  busy         out  1                   state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; all outputs 0 (cmd_ready=0
//    during reset, 1 the cycle after). Reset mid-transaction drops it.
//  - Legal opcodes: ADD8/16/32/64, S_ADD8/16/32/64 (simd_alu_defines.vh).
//  - States: IDLE, ISSUE, RESP. cmd_ready = (IDLE) | (RESP & rsp_ready).
//  - Accept edge T: alu_a/alu_b/alu_opcode <= cmd_*, tag latched,
//    cnt <= ALU_LATENCY, ->ISSUE. alu_* change only on accept edges; held
//    otherwise (ALU opcode is used combinationally on its output side).
//  - ISSUE: cnt>0: cnt--. cnt==0: rsp_data/ovf/udf <= alu_out/ovf/udf,
//    rsp_err<=0, ->RESP. rsp_valid rises ALU_LATENCY+1 cycles after T.
//  - Illegal opcode on accept: skip ISSUE; ->RESP next edge with
//    rsp_data=0, rsp_ovf=rsp_udf=0, rsp_err=1; alu_* still updated.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_ready. Ready w/o cmd_valid
//    ->IDLE, rsp_valid=0. Ready and cmd_valid same edge: response retired
//    and new command accepted (back-to-back, no idle cycle).
//  - cmd_* ignored when cmd_ready=0; rsp_valid never drops w/o rsp_ready.
// TESTING
//  - Reset: hold rst_n=0 3 cycles with cmd_valid=1 -> outputs 0, nothing
//    accepted; cmd_ready=1 first cycle after release.
//  - ADD32, all lanes a=0x00000001 b=0x00000002, tag=5 (real ALU) -> rsp_valid
//    2 cycles after accept, all lanes 0x00000003, ovf=udf=0, tag=5, err=0.
//  - S_ADD8, lane0 a=0x7F b=0x01, others 0 -> rsp_ovf[0]=1, others 0.
//  - Opcode outside legal set, tag=9 -> rsp_valid next cycle, rsp_err=1,
//    rsp_data=0, tag=9.
//  - rsp_ready low 5 cycles -> rsp_* constant, cmd_ready=0, alu_* unchanged.
//  - Back-to-back: rsp_ready=1, cmd_valid=1 every cycle, 4 cmds -> one
//    response per 3 cycles, tags in order; reset in ISSUE -> no rsp_valid.

Source files
------------

// File: rtl/simd_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// simd_alu_issue_ctrl
//
// Initiator side of the SIMD ALU operand/result interface. One command
// (a, b, opcode, tag) is accepted on a valid/ready port. Its operands and
// opcode are driven to the ALU and held until the next accepted command.
// After the ALU's fixed latency, the result and the per-byte-lane
// overflow/underflow flags are captured. They are returned with the tag on a
// valid/ready response port. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_a, cmd_b               operands (SIMD_DATA_WIDTH)
//   cmd_opcode                 ALU opcode (SIMD_OPC_WIDTH)
//   cmd_tag                    caller tag, echoed on the response
//   alu_a, alu_b, alu_opcode   operand/opcode drive to the ALU
//   alu_out, alu_ovf, alu_udf  ALU result and per-byte-lane flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_ovf, rsp_udf captured result and flags
//   rsp_tag                    tag of the returned transaction
//   rsp_err                    1 = illegal opcode, no ALU result captured
//   busy                       a transaction is in progress
//
// The OPC_* parameters must match the encodings in simd_alu_defines.vh.
// SIMD_DATA_WIDTH must be a multiple of 64, and ALU_LATENCY must be at
// least 1.
// ---------------------------------------------------------------------------
module simd_alu_issue_ctrl #(
    parameter int SIMD_DATA_WIDTH = 256,
    parameter int SIMD_OPC_WIDTH  = 5,
    parameter int TAG_WIDTH       = 4,
    parameter int ALU_LATENCY     = 1,
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_ADD8    = SIMD_OPC_WIDTH'(1),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_ADD16   = SIMD_OPC_WIDTH'(2),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_ADD32   = SIMD_OPC_WIDTH'(3),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_ADD64   = SIMD_OPC_WIDTH'(4),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_S_ADD8  = SIMD_OPC_WIDTH'(5),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_S_ADD16 = SIMD_OPC_WIDTH'(6),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_S_ADD32 = SIMD_OPC_WIDTH'(7),
    parameter logic [SIMD_OPC_WIDTH-1:0] OPC_S_ADD64 = SIMD_OPC_WIDTH'(8)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [SIMD_DATA_WIDTH-1:0]   cmd_a,
    input  logic [SIMD_DATA_WIDTH-1:0]   cmd_b,
    input  logic [SIMD_OPC_WIDTH-1:0]    cmd_opcode,
    input  logic [TAG_WIDTH-1:0]         cmd_tag,
    output logic [SIMD_DATA_WIDTH-1:0]   alu_a,
    output logic [SIMD_DATA_WIDTH-1:0]   alu_b,
    output logic [SIMD_OPC_WIDTH-1:0]    alu_opcode,
    input  logic [SIMD_DATA_WIDTH-1:0]   alu_out,
    input  logic [SIMD_DATA_WIDTH/8-1:0] alu_ovf,
    input  logic [SIMD_DATA_WIDTH/8-1:0] alu_udf,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [SIMD_DATA_WIDTH-1:0]   rsp_data,
    output logic [SIMD_DATA_WIDTH/8-1:0] rsp_ovf,
    output logic [SIMD_DATA_WIDTH/8-1:0] rsp_udf,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err_pend;   // accepted opcode was illegal
    logic             accept;
    logic             opc_legal;

    // NOTE: cmd_ready is gated by rst_n because it is a combinational
    // function of the state. Without the gate it would read 1 while the
    // block sits in reset.
    assign cmd_ready = rst_n & ((state == S_IDLE) | ((state == S_RESP) & rsp_ready));
    assign accept    = cmd_valid & cmd_ready;

    assign opc_legal = cmd_opcode inside {OPC_ADD8,   OPC_ADD16,   OPC_ADD32,   OPC_ADD64,
                                          OPC_S_ADD8, OPC_S_ADD16, OPC_S_ADD32, OPC_S_ADD64};

    // NOTE: every register in this block uses non-blocking assignments.
    // All flops then sample pre-edge values, which keeps simulation
    // consistent with the synthesised logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            err_pend   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ovf    <= '0;
            rsp_udf    <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // A new command can arrive in IDLE, or in RESP on the same edge
            // that retires the previous response (back-to-back).
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_opcode;
                rsp_tag    <= cmd_tag;
                rsp_valid  <= 1'b0;
                busy       <= 1'b1;
                state      <= S_ISSUE;
                err_pend   <= ~opc_legal;
                // An illegal opcode does not wait out the ALU latency. The
                // error response is presented one cycle after accept.
                cnt        <= opc_legal ? CNT_W'(ALU_LATENCY) : '0;
            end else begin
                case (state)
                    S_ISSUE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            rsp_data  <= err_pend ? '0 : alu_out;
                            rsp_ovf   <= err_pend ? '0 : alu_ovf;
                            rsp_udf   <= err_pend ? '0 : alu_udf;
                            rsp_err   <= err_pend;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        // The response stays up until the consumer takes it.
                        if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
